// File: rtl/xor_serial_arbiter_if.sv
// Request/operand/result bundle shared between the requesters and the
// bit-serial XOR engine. Requesters drive requests and operands; the
// engine drives grants, status and results.
interface xor_serial_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic             done;
  logic             done_id;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, y, parity, done, done_id
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, y, parity, done, done_id
  );
endinterface

// File: rtl/xor_serial_arbiter.sv
// Bit-serial XOR engine: a round-robin arbiter hands one of two requesters
// the single NOR-built XOR cell, whose operands are then streamed LSB-first,
// one bit per clock. Result word, parity and requester id are published
// together with a one-cycle done pulse.

// 1-bit XOR built only from 2-input NOR gates.
module xorFromNor (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  logic w_n1;
  logic w_n2;
  logic w_n3;
  logic w_n4;

  assign w_n1 = ~(i_a | i_b);
  assign w_n2 = ~(i_a | w_n1);
  assign w_n3 = ~(i_b | w_n1);
  assign w_n4 = ~(w_n2 | w_n3);   // XNOR
  assign o_y  = ~(w_n4 | w_n4);   // inverter made from a NOR
endmodule

module xor_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xor_serial_arbiter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             w_grant;     // IDLE edge that accepts a job
  logic             w_win;       // winning requester index
  logic             w_shift;     // SHIFT edge, one bit produced
  logic             w_finish;    // last SHIFT edge, publish results

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic             r_id;
  logic             r_last;      // index of the most recent grant

  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done;
  logic             r_done_id;
  logic             r_parity;
  logic [WIDTH-1:0] r_y;

  logic             w_bit;
  logic             w_par_next;
  logic [WIDTH-1:0] w_res_next;

  // The one shared XOR cell sees the current operand LSBs.
  xorFromNor u_xor (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .o_y (w_bit)
  );

  assign w_par_next = r_par ^ w_bit;

  // The result register only needs WIDTH-1 bits: the final bit produced goes
  // straight into y on the finishing edge together with the stored ones.
  generate
    if (WIDTH > 1) begin : g_res
      logic [WIDTH-2:0] r_res;

      assign w_res_next = {w_bit, r_res};

      // Partial result shifts right, new bits enter from the MSB side.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_res <= '0;
        end else if (w_grant) begin
          r_res <= '0;
        end else if (w_shift) begin
          r_res <= w_res_next[WIDTH-1:1];
        end
      end
    end else begin : g_res_single
      assign w_res_next = w_bit;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, arbitration and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_win        = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant      = 1'b1;
          // Contention goes to whoever was not served last.
          w_win        = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture at grant, then right shift one bit per SHIFT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (w_grant) begin
      r_a   <= w_win ? bus.a1 : bus.a0;
      r_b   <= w_win ? bus.b1 : bus.b0;
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (w_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      r_par <= w_par_next;
    end
  end

  // Winner bookkeeping; the pointer resets so requester 0 is favoured first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_id   <= w_win;
      r_last <= w_win;
    end
  end

  // One-cycle grant and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_gnt0 <= w_grant & ~w_win;
      r_gnt1 <= w_grant & w_win;
      r_done <= w_finish;
    end
  end

  // Published results hold until the next job completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_parity  <= 1'b0;
      r_done_id <= 1'b0;
    end else if (w_finish) begin
      r_y       <= w_res_next;
      r_parity  <= w_par_next;
      r_done_id <= r_id;
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.y       = r_y;
  assign bus.parity  = r_parity;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Bench for xor_serial_arbiter: a WIDTH=8 and a WIDTH=1 instance share clock
// and reset. Monitors push expected results on each grant and pop/compare
// them on each done.
module tb_xor_serial_arbiter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       id;
    logic [7:0] y;
    logic       par;
  } exp_t;

  exp_t sb8[$];
  exp_t sb1[$];
  int   gnt_log8[$];

  int gnt_cnt8  = 0;
  int done_cnt8 = 0;
  int cyc8      = 0;
  bit pend8     = 0;
  int gnt_cnt1  = 0;
  int done_cnt1 = 0;
  int cyc1      = 0;
  bit pend1     = 0;

  xor_serial_arbiter_if #(.WIDTH(8)) if8 ();
  xor_serial_arbiter_if #(.WIDTH(1)) if1 ();

  xor_serial_arbiter #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  xor_serial_arbiter #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // sel: 0 = WIDTH 8 grants, 1 = WIDTH 8 dones, 2 = WIDTH 1 grants, 3 = WIDTH 1 dones
  task automatic wait_count(input string tag, input int sel, input int target);
    int k;
    int cur;
    k = 0;
    cur = (sel == 0) ? gnt_cnt8 : (sel == 1) ? done_cnt8 : (sel == 2) ? gnt_cnt1 : done_cnt1;
    while (cur < target && k < 200) begin
      @(negedge clk);
      #1;
      k++;
      cur = (sel == 0) ? gnt_cnt8 : (sel == 1) ? done_cnt8 : (sel == 2) ? gnt_cnt1 : done_cnt1;
    end
    check(tag, 32'(cur >= target), 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // WIDTH=8 monitor: scoreboard push on grant, pop and compare on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb8.delete();
      pend8 = 0;
    end else begin
      if (if8.gnt0 || if8.gnt1) begin
        check("w8_gnt_exclusive", 32'(if8.gnt0 & if8.gnt1), 0);
        check("w8_busy_at_gnt", 32'(if8.busy), 1);
        e.id  = if8.gnt1;
        e.y   = if8.gnt1 ? (if8.a1 ^ if8.b1) : (if8.a0 ^ if8.b0);
        e.par = ^e.y;
        sb8.push_back(e);
        gnt_log8.push_back(int'(if8.gnt1));
        gnt_cnt8++;
        cyc8  = 1;
        pend8 = 1;
      end else if (pend8) begin
        cyc8++;
      end
      if (if8.done) begin
        done_cnt8++;
        check("w8_done_with_gnt", 32'(if8.gnt0 | if8.gnt1), 0);
        if (sb8.size() == 0) begin
          check("w8_unexpected_done", 1, 0);
        end else begin
          e = sb8.pop_front();
          $display("w8 job id=%0d y=%02h parity=%0d latency=%0d", if8.done_id, if8.y, if8.parity, cyc8);
          check("w8_y", 32'(if8.y), 32'(e.y));
          check("w8_parity", 32'(if8.parity), 32'(e.par));
          check("w8_done_id", 32'(if8.done_id), 32'(e.id));
          check("w8_latency", 32'(cyc8), 9);
        end
        pend8 = 0;
      end
    end
  end

  // WIDTH=1 monitor, same scheme.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb1.delete();
      pend1 = 0;
    end else begin
      if (if1.gnt0 || if1.gnt1) begin
        check("w1_gnt_exclusive", 32'(if1.gnt0 & if1.gnt1), 0);
        e.id  = if1.gnt1;
        e.y   = {7'd0, (if1.gnt1 ? (if1.a1 ^ if1.b1) : (if1.a0 ^ if1.b0))};
        e.par = ^e.y;
        sb1.push_back(e);
        gnt_cnt1++;
        cyc1  = 1;
        pend1 = 1;
      end else if (pend1) begin
        cyc1++;
      end
      if (if1.done) begin
        done_cnt1++;
        if (sb1.size() == 0) begin
          check("w1_unexpected_done", 1, 0);
        end else begin
          e = sb1.pop_front();
          $display("w1 job id=%0d y=%0d parity=%0d latency=%0d", if1.done_id, if1.y, if1.parity, cyc1);
          check("w1_y", 32'(if1.y), 32'(e.y));
          check("w1_parity", 32'(if1.parity), 32'(e.par));
          check("w1_latency", 32'(cyc1), 2);
        end
        pend1 = 0;
      end
    end
  end

  initial begin
    int base_g;
    int base_d;
    int g;
    logic [1:0] ab;
    logic exp_w1 [4];
    exp_w1 = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if8.req0 = 1'($urandom); if8.req1 = 1'($urandom);
      if8.a0 = 8'($urandom); if8.b0 = 8'($urandom);
      if8.a1 = 8'($urandom); if8.b1 = 8'($urandom);
      if1.req0 = 1'($urandom); if1.req1 = 1'($urandom);
      if1.a0 = 1'($urandom); if1.b0 = 1'($urandom);
      if1.a1 = 1'($urandom); if1.b1 = 1'($urandom);
      cycles(1);
    end
    check("rst_gnt", {if8.gnt0, if8.gnt1, if1.gnt0, if1.gnt1}, 0);
    check("rst_busy", {if8.busy, if1.busy}, 0);
    check("rst_done", {if8.done, if1.done}, 0);
    check("rst_y", {if8.y, if1.y}, 0);
    check("rst_parity_id", {if8.parity, if8.done_id, if1.parity, if1.done_id}, 0);

    if8.req0 = 0; if8.req1 = 0; if1.req0 = 0; if1.req1 = 0;
    rst = 1'b0;
    cycles(3);
    check("post_rst_quiet", {if8.busy, if8.done, if8.y, if8.gnt0, if8.gnt1}, 0);

    // Single job on requester 0.
    if8.a0 = 8'hA5; if8.b0 = 8'h3C; if8.req0 = 1;
    wait_count("t1_gnt_timeout", 0, gnt_cnt8 + 1);
    check("t1_gnt0", 32'(if8.gnt0), 1);
    if8.req0 = 0;
    cycles(1);
    check("t1_gnt_one_cycle", 32'(if8.gnt0), 0);
    wait_count("t1_done_timeout", 1, done_cnt8 + 1);
    check("t1_y_const", 32'(if8.y), 32'h99);
    check("t1_parity_const", 32'(if8.parity), 0);
    cycles(1);
    check("t1_done_one_cycle", 32'(if8.done), 0);

    // Both requests held from reset: round robin 0,1,0,1.
    if8.a0 = 8'h01; if8.b0 = 8'h00; if8.a1 = 8'hF0; if8.b1 = 8'h0F;
    if8.req0 = 1; if8.req1 = 1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    gnt_log8.delete();
    base_g = gnt_cnt8;
    base_d = done_cnt8;
    wait_count("t2_gnt_timeout", 0, base_g + 4);
    if8.req0 = 0; if8.req1 = 0;
    wait_count("t2_done_timeout", 1, base_d + 4);
    for (int i = 0; i < 4; i++) begin
      g = (gnt_log8.size() > 0) ? gnt_log8.pop_front() : -1;
      check("t2_grant_order", 32'(g), 32'(i % 2));
    end

    // Request pulse on requester 1 while a requester 0 job is shifting.
    if8.a0 = 8'h12; if8.b0 = 8'h34; if8.req0 = 1;
    base_g = gnt_cnt8;
    base_d = done_cnt8;
    wait_count("t3_gnt_timeout", 0, base_g + 1);
    if8.req0 = 0;
    cycles(3);
    if8.req1 = 1;
    cycles(2);
    if8.req1 = 0;
    cycles(14);
    check("t3_grant_count", 32'(gnt_cnt8 - base_g), 1);
    check("t3_done_count", 32'(done_cnt8 - base_d), 1);

    // Asynchronous reset in the middle of a job.
    if8.a0 = 8'hFF; if8.b0 = 8'h00; if8.req0 = 1;
    base_d = done_cnt8;
    wait_count("t4_gnt_timeout", 0, gnt_cnt8 + 1);
    if8.req0 = 0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(if8.busy), 0);
    check("t4_rst_y", 32'(if8.y), 0);
    check("t4_rst_flags", {if8.gnt0, if8.gnt1, if8.done, if8.parity, if8.done_id}, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cycles(12);
    check("t4_no_done", 32'(done_cnt8 - base_d), 0);
    if8.a1 = 8'h0F; if8.b1 = 8'h0F; if8.req1 = 1;
    wait_count("t4_gnt_timeout2", 0, gnt_cnt8 + 1);
    check("t4_gnt1", 32'(if8.gnt1), 1);
    if8.req1 = 0;
    wait_count("t4_done_timeout", 1, base_d + 1);
    check("t4_y_zero", 32'(if8.y), 0);
    check("t4_done_id", 32'(if8.done_id), 1);

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      if1.a0 = ab[1]; if1.b0 = ab[0]; if1.req0 = 1;
      base_d = done_cnt1;
      wait_count("t5_gnt_timeout", 2, gnt_cnt1 + 1);
      if1.req0 = 0;
      wait_count("t5_done_timeout", 3, base_d + 1);
      check("t5_y_table", 32'(if1.y), 32'(exp_w1[i]));
      cycles(2);
    end

    check("end_sb_empty", 32'(sb8.size() + sb1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
